hazard_unit: RTL and testbench

Pipeline hazard detection and stall controller for the 5-stage MIPS datapath. Sits in the ID stage, directly upstream of the forwarding unit. It inspects the IF/ID instruction against the ID/EX and EX/MEM destinations and freezes PC and IF/ID while injecting bubbles into ID/EX. It covers every case forwarding cannot resolve: load-use, and ID-stage branch compares whose source is not yet in EX/MEM as an ALU result. A small FSM enforces multi-cycle stalls, and a saturating counter records stall cycles for performance measurement.

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_unit.sv | 82 ++++++++
 tb/tb_hazard_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Bundle of pipeline-register fields the hazard unit inspects and the
// PC / IF/ID / ID/EX control it returns to the datapath.
interface hazard_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic             IDEXmemRead;
  logic             IDEXregWr;
  logic [REG_W-1:0] IDEXrd;
  logic             EXMEMmemRead;
  logic [REG_W-1:0] EXMEMrd;
  logic [REG_W-1:0] IFIDrs;
  logic [REG_W-1:0] IFIDrt;
  logic             IFIDusesRt;
  logic             branch;
  logic             PCwrite;
  logic             IFIDwrite;
  logic             IDEXflush;
  logic [CNT_W-1:0] stallCount;

  // Datapath side: supplies pipeline state, consumes stall control
  modport master (
    output IDEXmemRead, IDEXregWr, IDEXrd, EXMEMmemRead, EXMEMrd,
           IFIDrs, IFIDrt, IFIDusesRt, branch,
    input  PCwrite, IFIDwrite, IDEXflush, stallCount
  );

  // Hazard unit side
  modport slave (
    input  IDEXmemRead, IDEXregWr, IDEXrd, EXMEMmemRead, EXMEMrd,
           IFIDrs, IFIDrt, IFIDusesRt, branch,
    output PCwrite, IFIDwrite, IDEXflush, stallCount
  );
endinterface

// File: rtl/hazard_unit.sv
// ID-stage hazard detector: freezes PC and IF/ID and bubbles ID/EX for load-use
// and unresolved branch-compare sources; counts stall cycles (saturating).
module hazard_unit (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       need;
  logic             stall;

  function automatic logic match_x(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt,
                                   input logic             uses_rt);
    return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Branches compare in ID, so rt is always a source for them
  function automatic logic match_b(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

  // Required bubbles for the instruction currently in ID, highest first
  always_comb begin
    need = 2'd0;
    if (hz.branch && hz.IDEXmemRead && match_b(hz.IDEXrd, hz.IFIDrs, hz.IFIDrt))
      need = 2'd2;
    else if (hz.branch && hz.IDEXregWr && !hz.IDEXmemRead &&
             match_b(hz.IDEXrd, hz.IFIDrs, hz.IFIDrt))
      need = 2'd1;
    else if (hz.branch && hz.EXMEMmemRead && match_b(hz.EXMEMrd, hz.IFIDrs, hz.IFIDrt))
      need = 2'd1;
    else if (!hz.branch && hz.IDEXmemRead &&
             match_x(hz.IDEXrd, hz.IFIDrs, hz.IFIDrt, hz.IFIDusesRt))
      need = 2'd1;
  end

  // Next state, stall decision and counter update
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        stall = (need != 2'd0);
        if (need == 2'd2) state_d = HOLD;
      end
      HOLD: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.PCwrite    = !stall;
  assign hz.IFIDwrite  = !stall;
  assign hz.IDEXflush  = stall;
  assign hz.stallCount = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized check of hazard_unit against a bubble-budget model.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   m_count = 0;
  int   m_extra = 0;

  hazard_if hif ();

  hazard_unit u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bubbles the ID instruction requires, straight from the hazard rules
  function automatic int ref_need();
    bit hit_ex_b, hit_mem_b, hit_ex_x;
    hit_ex_b  = (hif.IDEXrd != 0) && (hif.IDEXrd == hif.IFIDrs || hif.IDEXrd == hif.IFIDrt);
    hit_mem_b = (hif.EXMEMrd != 0) && (hif.EXMEMrd == hif.IFIDrs || hif.EXMEMrd == hif.IFIDrt);
    hit_ex_x  = (hif.IDEXrd != 0) &&
                (hif.IDEXrd == hif.IFIDrs || (hif.IFIDusesRt && hif.IDEXrd == hif.IFIDrt));
    if (hif.branch) begin
      if (hif.IDEXmemRead && hit_ex_b) return 2;
      if (hif.IDEXregWr && hit_ex_b) return 1;
      if (hif.EXMEMmemRead && hit_mem_b) return 1;
      return 0;
    end
    return (hif.IDEXmemRead && hit_ex_x) ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    hif.IDEXmemRead = 0; hif.IDEXregWr = 0; hif.IDEXrd = 0;
    hif.EXMEMmemRead = 0; hif.EXMEMrd = 0;
    hif.IFIDrs = 0; hif.IFIDrt = 0; hif.IFIDusesRt = 0; hif.branch = 0;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge
  task automatic cycle(input string tag, input bit chk_en);
    bit exp_stall;
    int nd;
    @(negedge clk);
    nd = ref_need();
    exp_stall = !rst && (m_extra > 0 || nd > 0);
    if (chk_en) begin
      chk({tag, ".pcwrite"},   32'(hif.PCwrite),    32'(!exp_stall));
      chk({tag, ".ifidwrite"}, 32'(hif.IFIDwrite),  32'(!exp_stall));
      chk({tag, ".idexflush"}, 32'(hif.IDEXflush),  32'(exp_stall));
      chk({tag, ".count"},     32'(hif.stallCount), 32'(m_count));
    end
    @(posedge clk);
    if (rst) begin
      m_count = 0;
      m_extra = 0;
    end else begin
      if (exp_stall && m_count < 65535) m_count++;
      m_extra = (m_extra > 0) ? m_extra - 1 : ((nd == 2) ? 1 : 0);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle("reset", 1);
    rst = 0;
  endtask

  initial begin
    // Reset with a live load-use hazard on the inputs
    rst = 1;
    clear_inputs();
    hif.IDEXmemRead = 1; hif.IDEXrd = 8; hif.IFIDrs = 8;
    @(posedge clk); #1;
    cycle("rst0", 1);
    cycle("rst1", 1);
    chk("rst.count", 32'(hif.stallCount), 32'd0);
    rst = 0;

    // Load-use: one bubble
    cycle("lu.stall", 1);
    chk("lu.flush_seen", 32'(m_count), 32'd1);
    clear_inputs();
    cycle("lu.free", 1);
    chk("lu.count", 32'(hif.stallCount), 32'd1);

    // Branch on load in EX: two bubbles, second ignores inputs
    do_reset();
    clear_inputs();
    hif.IDEXmemRead = 1; hif.IDEXrd = 9; hif.branch = 1; hif.IFIDrt = 9;
    cycle("bl.stall1", 1);
    clear_inputs();
    cycle("bl.stall2", 1);
    chk("bl.hold_flush", 32'(m_count), 32'd2);
    cycle("bl.free", 1);
    chk("bl.count", 32'(hif.stallCount), 32'd2);

    // Branch on ALU result in EX: one bubble
    do_reset();
    clear_inputs();
    hif.IDEXregWr = 1; hif.IDEXrd = 10; hif.IFIDrs = 10; hif.branch = 1;
    cycle("ba.stall", 1);
    clear_inputs();
    cycle("ba.free", 1);
    chk("ba.count", 32'(hif.stallCount), 32'd1);

    // Branch on load in MEM: one bubble
    hif.EXMEMmemRead = 1; hif.EXMEMrd = 12; hif.IFIDrs = 12; hif.branch = 1;
    cycle("bm.stall", 1);
    clear_inputs();
    cycle("bm.free", 1);

    // Register 0 and unused rt never stall
    hif.IDEXmemRead = 1; hif.IDEXrd = 0; hif.IFIDrs = 0;
    cycle("r0", 1);
    chk("r0.flush", 32'(hif.IDEXflush), 32'd0);
    hif.IDEXrd = 5; hif.IFIDrs = 1; hif.IFIDrt = 5; hif.IFIDusesRt = 0;
    cycle("rtunused", 1);
    chk("rtunused.pc", 32'(hif.PCwrite), 32'd1);
    hif.IFIDusesRt = 1;
    cycle("rtused", 1);
    clear_inputs();

    // Saturation over 65537 stall cycles
    do_reset();
    hif.IDEXmemRead = 1; hif.IDEXrd = 3; hif.IFIDrs = 3;
    for (int i = 0; i < 65537; i++) cycle("sat", (i < 4) || (i > 65530));
    chk("sat.count", 32'(hif.stallCount), 32'hFFFF);

    // Reset during HOLD aborts the second bubble
    clear_inputs();
    hif.IDEXmemRead = 1; hif.IDEXrd = 9; hif.branch = 1; hif.IFIDrs = 9;
    cycle("hr.enter", 1);
    rst = 1;
    clear_inputs();
    cycle("hr.rst", 1);
    chk("hr.count", 32'(hif.stallCount), 32'd0);
    rst = 0;
    cycle("hr.after", 1);
    chk("hr.free", 32'(hif.IDEXflush), 32'd0);

    // Random traffic on a narrow register range to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 63) == 0);
      hif.IDEXmemRead  = 1'($urandom_range(0, 1));
      hif.IDEXregWr    = 1'($urandom_range(0, 1));
      hif.IDEXrd       = 5'($urandom_range(0, 3));
      hif.EXMEMmemRead = 1'($urandom_range(0, 1));
      hif.EXMEMrd      = 5'($urandom_range(0, 3));
      hif.IFIDrs       = 5'($urandom_range(0, 3));
      hif.IFIDrt       = 5'($urandom_range(0, 3));
      hif.IFIDusesRt   = 1'($urandom_range(0, 1));
      hif.branch       = 1'($urandom_range(0, 1));
      cycle("rand", 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
